onn_pattern_loader: RTL and testbench

- Parametrised serial-to-parallel pattern loader for the oscillatory neural network (ONN) array.
- Receives a ROWS x COLS image as a serial bit stream, PHASE_W bits per pixel, MSB-first, in row-major order.
- Assembles the pixels in a shadow buffer and commits them atomically to the phase vector that drives the neuron array, so the neurons never see a partial pattern.
- Supports serial readback of the committed phases for debug, plus abort and restart handling.

---
 rtl/onn_pkg.sv | 15 +
 rtl/onn_pixel_accum.sv | 56 +++++
 rtl/onn_pattern_loader.sv | 155 +++++++++++++++
 tb/tb_onn_pattern_loader.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/onn_pkg.sv
// Shared ONN constants and the pattern loader state encoding.
package onn_pkg;

  localparam int unsigned ONN_ROWS    = 5;
  localparam int unsigned ONN_COLS    = 3;
  localparam int unsigned ONN_PHASE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMMIT,
    ST_READBACK
  } loader_state_e;

endpackage

// File: rtl/onn_pixel_accum.sv
// MSB-first serial accumulator for one pixel phase; pulses o_pixel_ready
// (registered) the cycle after the last bit of a pixel is sampled.
module onn_pixel_accum
  import onn_pkg::*;
#(
  parameter int unsigned PHASE_W = ONN_PHASE_W
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clear,
  input  logic               i_bit_valid,
  input  logic               i_bit_in,
  output logic [PHASE_W-1:0] o_pixel,
  output logic               o_pixel_ready
);

  localparam int unsigned BC_W = (PHASE_W > 1) ? $clog2(PHASE_W) : 1;

  logic [PHASE_W-1:0] r_acc;
  logic [PHASE_W-1:0] r_pixel;
  logic [BC_W-1:0]    r_cnt;
  logic               r_ready;
  logic [PHASE_W-1:0] w_next;
  logic               w_last;

  assign w_next = (r_acc << 1) | PHASE_W'(i_bit_in);
  assign w_last = i_bit_valid && (r_cnt == BC_W'(PHASE_W - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc   <= '0;
      r_pixel <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else if (i_clear) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      if (w_last) begin
        r_acc   <= '0;
        r_cnt   <= '0;
        r_pixel <= w_next;
        r_ready <= 1'b1;
      end else if (i_bit_valid) begin
        r_acc <= w_next;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_pixel       = r_pixel;
  assign o_pixel_ready = r_ready;

endmodule

// File: rtl/onn_pattern_loader.sv
// Serial-to-parallel ONN pattern loader: shadow-buffered atomic commit to
// phi_out, frame abort on restart, and serial readback of the committed phases.
module onn_pattern_loader
  import onn_pkg::*;
#(
  parameter int unsigned ROWS    = ONN_ROWS,
  parameter int unsigned COLS    = ONN_COLS,
  parameter int unsigned PHASE_W = ONN_PHASE_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         bit_in,
  input  logic                         bit_valid,
  input  logic                         rb_req,
  output logic [ROWS*COLS*PHASE_W-1:0] phi_out,
  output logic                         load_done,
  output logic                         frame_err,
  output logic                         busy,
  output logic                         rb_bit,
  output logic                         rb_valid
);

  localparam int unsigned N     = ROWS * COLS;
  localparam int unsigned TOTAL = N * PHASE_W;
  localparam int unsigned CNT_W = $clog2(N * PHASE_W + 1);
  localparam int unsigned PIX_W = $clog2(N + 1);

  loader_state_e      r_state;
  loader_state_e      w_next_state;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [PIX_W-1:0]   r_pix_cnt;
  logic [CNT_W-1:0]   r_rb_cnt;
  logic [TOTAL-1:0]   r_shadow;
  logic [TOTAL-1:0]   r_phi;
  logic [TOTAL-1:0]   r_rb_sr;
  logic [TOTAL-1:0]   w_rb_img;
  logic               r_load_done;
  logic               r_frame_err;
  logic               w_abort;
  logic               w_clear;
  logic               w_accept;
  logic               w_rb_start;
  logic [PHASE_W-1:0] w_acc_pixel;
  logic               w_acc_ready;

  onn_pixel_accum #(
    .PHASE_W(PHASE_W)
  ) u_accum (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_clear      (w_clear),
    .i_bit_valid  (w_accept),
    .i_bit_in     (bit_in),
    .o_pixel      (w_acc_pixel),
    .o_pixel_ready(w_acc_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // The accumulator registers its pixel, so LOAD spends one extra cycle with a
  // full bit count while the last pixel lands in the shadow buffer.
  always_comb begin
    w_next_state = r_state;
    w_abort      = 1'b0;
    w_clear      = 1'b0;
    w_accept     = 1'b0;
    w_rb_start   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state = ST_LOAD;
          w_clear      = 1'b1;
        end else if (rb_req) begin
          w_next_state = ST_READBACK;
          w_rb_start   = 1'b1;
        end
      end
      ST_LOAD: begin
        if (r_bit_cnt == CNT_W'(TOTAL)) begin
          w_next_state = ST_COMMIT;
        end else if (start) begin
          w_abort = 1'b1;
          w_clear = 1'b1;
        end else begin
          w_accept = bit_valid;
        end
      end
      ST_COMMIT: w_next_state = ST_IDLE;
      ST_READBACK: begin
        if (r_rb_cnt == CNT_W'(TOTAL - 1)) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Neuron order reversed so neuron 0 sits at the top of the shift register.
  always_comb begin
    w_rb_img = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_rb_img[(N-1-k)*PHASE_W +: PHASE_W] = r_phi[k*PHASE_W +: PHASE_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt   <= '0;
      r_pix_cnt   <= '0;
      r_rb_cnt    <= '0;
      r_shadow    <= '0;
      r_phi       <= '0;
      r_rb_sr     <= '0;
      r_load_done <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_load_done <= (r_state == ST_COMMIT);
      r_frame_err <= w_abort;

      if (w_clear) begin
        r_bit_cnt <= '0;
        r_pix_cnt <= '0;
      end else begin
        if (w_accept)    r_bit_cnt <= r_bit_cnt + 1'b1;
        if (w_acc_ready) r_pix_cnt <= r_pix_cnt + 1'b1;
      end

      if (w_acc_ready) begin
        for (int unsigned k = 0; k < N; k++) begin
          if (r_pix_cnt == PIX_W'(k)) r_shadow[k*PHASE_W +: PHASE_W] <= w_acc_pixel;
        end
      end

      if (r_state == ST_COMMIT) r_phi <= r_shadow;

      if (w_rb_start) begin
        r_rb_sr  <= w_rb_img;
        r_rb_cnt <= '0;
      end else if (r_state == ST_READBACK) begin
        r_rb_sr  <= r_rb_sr << 1;
        r_rb_cnt <= r_rb_cnt + 1'b1;
      end
    end
  end

  assign phi_out   = r_phi;
  assign load_done = r_load_done;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != ST_IDLE);
  assign rb_valid  = (r_state == ST_READBACK);
  assign rb_bit    = rb_valid & r_rb_sr[TOTAL-1];

endmodule

// File: tb/tb_onn_pattern_loader.sv
// Randomized self-checking bench for onn_pattern_loader against a pixel-level model.
module tb_onn_pattern_loader;

  localparam int unsigned N0  = 15;
  localparam int unsigned PW0 = 4;
  localparam int unsigned T0  = N0 * PW0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, bit_in = 1'b0, bit_valid = 1'b0, rb_req = 1'b0;
  logic [T0-1:0] phi_out;
  logic          load_done, frame_err, busy, rb_bit, rb_valid;

  logic          s_start = 1'b0, s_bit_in = 1'b0, s_bit_valid = 1'b0, s_rb_req = 1'b0;
  logic [11:0]   s_phi_out;
  logic          s_load_done, s_frame_err, s_busy, s_rb_bit, s_rb_valid;

  int unsigned   n_checks = 0;
  int unsigned   n_errors = 0;

  logic [PW0-1:0] m_pix [N0];
  logic [T0-1:0]  m_phi = '0;
  logic [2:0]     p1 [4] = '{3'b101, 3'b010, 3'b111, 3'b001};

  onn_pattern_loader u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
    .rb_req(rb_req), .phi_out(phi_out), .load_done(load_done), .frame_err(frame_err),
    .busy(busy), .rb_bit(rb_bit), .rb_valid(rb_valid)
  );

  onn_pattern_loader #(.ROWS(2), .COLS(2), .PHASE_W(3)) u_dut_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .bit_in(s_bit_in), .bit_valid(s_bit_valid),
    .rb_req(s_rb_req), .phi_out(s_phi_out), .load_done(s_load_done), .frame_err(s_frame_err),
    .busy(s_busy), .rb_bit(s_rb_bit), .rb_valid(s_rb_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [T0-1:0] pack_frame();
    logic [T0-1:0] v;
    v = '0;
    for (int unsigned k = 0; k < N0; k++) v[k*PW0 +: PW0] = m_pix[k];
    return v;
  endfunction

  function automatic logic [63:0] stream_word(input logic [T0-1:0] phi);
    logic [63:0] w;
    w = '0;
    for (int unsigned k = 0; k < N0; k++) w = (w << PW0) | 64'(phi[k*PW0 +: PW0]);
    return w;
  endfunction

  task automatic hold_checks();
    check_eq("phi_hold", 64'(phi_out), 64'(m_phi));
    check_eq("ld_low", 64'(load_done), 64'd0);
    check_eq("rbv_low", 64'(rb_valid), 64'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // gap_mode: 0 continuous, 1 idle cycle before every bit, 2 random idle cycles
  task automatic stream_frame(input int unsigned nbits, input int unsigned gap_mode);
    for (int unsigned i = 0; i < nbits; i++) begin
      logic [PW0-1:0] px;
      px = m_pix[i / PW0];
      if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
        bit_valid = 1'b0;
        bit_in    = 1'($urandom);
        tick();
        hold_checks();
      end
      bit_valid = 1'b1;
      bit_in    = px[PW0-1-(i % PW0)];
      tick();
      hold_checks();
    end
    bit_valid = 1'b0;
  endtask

  task automatic finish_commit();
    tick();
    check_eq("ld_e1", 64'(load_done), 64'd0);
    check_eq("phi_e1", 64'(phi_out), 64'(m_phi));
    check_eq("busy_e1", 64'(busy), 64'd1);
    tick();
    m_phi = pack_frame();
    check_eq("ld_e2", 64'(load_done), 64'd1);
    check_eq("phi_commit", 64'(phi_out), 64'(m_phi));
    check_eq("busy_after", 64'(busy), 64'd0);
    tick();
    check_eq("ld_pulse", 64'(load_done), 64'd0);
  endtask

  task automatic do_readback(input bit poke_start);
    logic [63:0] word;
    int unsigned n;
    rb_req = 1'b1;
    tick();
    rb_req = 1'b0;
    word = '0;
    n = 0;
    while (rb_valid === 1'b1 && n < T0 + 8) begin
      word = {word[62:0], rb_bit};
      n++;
      if (poke_start && n == 20) start = 1'b1;
      tick();
      start = 1'b0;
    end
    check_eq("rb_count", 64'(n), 64'(T0));
    check_eq("rb_stream", word, stream_word(m_phi));
    check_eq("rb_bit_idle", 64'(rb_bit), 64'd0);
    check_eq("rb_busy_after", 64'(busy), 64'd0);
    check_eq("rb_phi_keep", 64'(phi_out), 64'(m_phi));
  endtask

  task automatic set_pattern_8800();
    for (int unsigned k = 0; k < N0; k++) m_pix[k] = (k % 3 != 2) ? 4'h8 : 4'h0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    m_phi = '0;
    tick();
    check_eq("rst_phi", 64'(phi_out), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    repeat (2) tick();
    check_eq("rst_phi", 64'(phi_out), 64'd0);
    check_eq("rst_ld", 64'(load_done), 64'd0);
    check_eq("rst_ferr", 64'(frame_err), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_rbv", 64'(rb_valid), 64'd0);
    check_eq("rst_rbb", 64'(rb_bit), 64'd0);
    check_eq("rst_small_phi", 64'(s_phi_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Continuous 1000/1000/0000 frame, then readback with a stray start.
    set_pattern_8800();
    pulse_start();
    stream_frame(T0, 0);
    finish_commit();
    do_readback(1'b1);

    // Same frame with a gap before every bit, from a fresh reset.
    apply_reset();
    pulse_start();
    stream_frame(T0, 1);
    finish_commit();

    // All-F frame, then abort after 23 bits, then all-3 frame.
    for (int unsigned k = 0; k < N0; k++) m_pix[k] = 4'hF;
    pulse_start();
    stream_frame(T0, 0);
    finish_commit();
    for (int unsigned k = 0; k < N0; k++) m_pix[k] = 4'h3;
    pulse_start();
    stream_frame(23, 0);
    start = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
    tick();
    start = 1'b0; bit_valid = 1'b0;
    check_eq("ferr_pulse", 64'(frame_err), 64'd1);
    check_eq("ferr_phi", 64'(phi_out), 64'(m_phi));
    check_eq("ferr_busy", 64'(busy), 64'd1);
    tick();
    check_eq("ferr_single", 64'(frame_err), 64'd0);
    stream_frame(T0, 0);
    finish_commit();

    // start and rb_req together in IDLE: load wins.
    start = 1'b1; rb_req = 1'b1;
    tick();
    start = 1'b0; rb_req = 1'b0;
    check_eq("both_busy", 64'(busy), 64'd1);
    check_eq("both_rbv", 64'(rb_valid), 64'd0);
    for (int unsigned k = 0; k < N0; k++) m_pix[k] = 4'($urandom);
    stream_frame(T0, 2);
    finish_commit();

    // Random frames with random gaps, each read back.
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned k = 0; k < N0; k++) m_pix[k] = 4'($urandom);
      pulse_start();
      stream_frame(T0, 2);
      finish_commit();
      do_readback(1'($urandom));
    end

    // Reset in the middle of a load clears everything immediately.
    for (int unsigned k = 0; k < N0; k++) m_pix[k] = 4'($urandom);
    pulse_start();
    stream_frame(30, 0);
    #2;
    rst_n = 1'b0;
    #1;
    m_phi = '0;
    check_eq("mrst_phi", 64'(phi_out), 64'd0);
    check_eq("mrst_busy", 64'(busy), 64'd0);
    check_eq("mrst_ld", 64'(load_done), 64'd0);
    check_eq("mrst_ferr", 64'(frame_err), 64'd0);
    check_eq("mrst_rbv", 64'(rb_valid), 64'd0);
    check_eq("mrst_rbb", 64'(rb_bit), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 2x2 array, 3-bit phases.
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    for (int unsigned i = 0; i < 12; i++) begin
      logic [2:0] px;
      px = p1[i / 3];
      s_bit_valid = 1'b1;
      s_bit_in    = px[2 - (i % 3)];
      tick();
    end
    s_bit_valid = 1'b0;
    tick();
    check_eq("small_ld_e1", 64'(s_load_done), 64'd0);
    check_eq("small_phi_e1", 64'(s_phi_out), 64'd0);
    tick();
    check_eq("small_ld_e2", 64'(s_load_done), 64'd1);
    check_eq("small_phi", 64'(s_phi_out), 64'(12'b001_111_010_101));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
